my_sq_demod_gate: RTL and testbench
===================================

// Module: my_sq_demod_gate
// PURPOSE
//  Square-wave modulation generator and synchronous demodulator feeding the moving-average filter.
//  - Drives o_mod to the phase modulator.
//  - Integrates ADC samples over the +/- half-periods, skipping i_ignor settling samples per half.
//  - Once per full period, emits the signed error (pos - neg) on o_err with a 1-cycle o_step_trig.
//  - o_err / o_step_trig connect directly to the filter's din / trig inputs.
// PARAMETERS
//  DATA_W  14  ADC sample width (signed two's complement)
//  CNT_W   16  width of i_freq / i_ignor / half-period counter
//  - Elaboration error if DATA_W + CNT_W > 31.
// PORTS
//  clk          in   1        system clock; all logic on rising edge
//  n_rst        in   1        asynchronous, active-low reset
//  i_en         in   1        run enable; 0 = idle
//  i_freq       in   CNT_W    half-period length in clk cycles
//  i_ignor      in   CNT_W    samples skipped at the start of each half
//  i_adc        in   DATA_W   signed ADC sample, valid every clk
//  o_mod        out  1        modulation square wave (1 = POS half)
//  o_err        out  32       signed demodulated error, sign-extended
//  o_step_trig  out  1        1-cycle strobe, high on the cycle o_err updates
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, acc_pos=acc_neg=0, o_mod=0, o_err=0, o_step_trig=0.
//  - Reset asserted mid-period: same values immediately; no strobe is issued.
//  - FSM states: IDLE, POS, NEG.
//    - IDLE -> POS on the first edge with i_en=1. On that edge: cnt<=0, accumulators cleared,
//      i_freq/i_ignor latched into f_q/ig_q.
//    - f_q = max(i_freq, 2).
//    - POS: o_mod=1. cnt increments every cycle. At cnt==f_q-1: ->NEG, cnt<=0.
//    - NEG: o_mod=0. At cnt==f_q-1: ->POS, cnt<=0, o_err/o_step_trig updated (below).
//      The same edge clears the accumulators and re-latches f_q/ig_q.
//  - Config inputs take effect only at period boundaries; changes mid-period are ignored.
//  - Accumulation: in POS/NEG, when cnt >= ig_q, add sign-extended i_adc to acc_pos/acc_neg.
//    - Accumulator width = DATA_W + CNT_W bits; cannot overflow.
//  - Output, on the last NEG edge (current sample included if cnt >= ig_q):
//    - o_err <= acc_pos - (acc_neg + sample), computed in 32 bits (exact by width rule).
//    - o_step_trig <= 1 for exactly that one cycle; 0 in all other cycles.
//  - Strobe rate: one strobe per 2*f_q cycles.
//    - First strobe arrives 2*f_q cycles after leaving IDLE.
//  - ig_q >= f_q: nothing accumulated; o_err <= 0, strobe still issued.
//  - i_en=0 while in POS/NEG: on the next edge go to IDLE, o_mod<=0, accumulators cleared.
//    - o_err holds its last value; no strobe.
//    - i_en=0 on the exact last-NEG edge: IDLE wins, no strobe.
// CONFIGURATION
//  MYDEMOD_POL_SEL_EN
//  - Defined: adds port i_pol (in, 1), latched at the period boundary like i_freq.
//    - i_pol=1 outputs o_err = neg - pos.
//    - i_pol=0 outputs o_err = pos - neg.
//  - Undefined: no i_pol port; o_err = pos - neg always.
// TESTING
//  - Reset/idle: n_rst=0, then i_en=0 for 100 clk.
//    -> o_mod=0, o_err=0, o_step_trig never high.
//  - Basic: i_freq=10, i_ignor=2; i_adc=+100 in POS, -50 in NEG.
//    -> o_step_trig every 20 clk, first 20 clk after enable; o_err=1200 (8*100 + 8*50).
//  - Clamp/skip: i_freq=1 -> period=4 clk. i_freq=10, i_ignor=12 -> o_err=0 with strobe every 20 clk.
//  - Full scale: i_freq=65535, i_ignor=0; i_adc=+8191 in POS, -8192 in NEG.
//    -> o_err=1073659905, no wrap.
//  - Abort: drop i_en at NEG cnt=5 and re-enable 3 clk later.
//    -> no strobe; the next strobe is exactly 2*f_q after re-entry to POS.
//  - Mid-period config change: i_freq 10->6 at POS cnt=3 -> current period stays 20 clk, next is 12.
//    - With MYDEMOD_POL_SEL_EN and i_pol=1, the basic case gives o_err=-1200.

Source files
------------

// File: rtl/my_sq_demod_gate.sv
// Square-wave modulation generator with synchronous demodulator: integrates ADC samples over +/- halves
// and strobes the signed error once per period. Optional polarity select: define MYDEMOD_POL_SEL_EN.
module my_sq_demod_gate #(
    parameter int DATA_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_en,
    input  logic [CNT_W-1:0]         i_freq,
    input  logic [CNT_W-1:0]         i_ignor,
    input  logic signed [DATA_W-1:0] i_adc,
`ifdef MYDEMOD_POL_SEL_EN
    input  logic                     i_pol,
`endif
    output logic                     o_mod,
    output logic signed [31:0]       o_err,
    output logic                     o_step_trig
);

    localparam int ACC_W = DATA_W + CNT_W;

    generate
        if (DATA_W + CNT_W > 31) begin : g_width_check
            $error("my_sq_demod_gate: DATA_W + CNT_W must not exceed 31");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, POS, NEG} state_t;

    state_t                   state_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         f_q_reg;
    logic [CNT_W-1:0]         ig_q_reg;
    logic signed [ACC_W-1:0]  acc_pos_reg;
    logic signed [ACC_W-1:0]  acc_neg_reg;
`ifdef MYDEMOD_POL_SEL_EN
    logic                     pol_q_reg;
`endif

    logic                     sample_en;
    logic                     last_cnt;
    logic [CNT_W-1:0]         freq_clamped;
    logic signed [ACC_W-1:0]  adc_ext;
    logic signed [31:0]       pos_32;
    logic signed [31:0]       neg_32;
    logic signed [31:0]       err_next;

    assign sample_en    = (cnt_reg >= ig_q_reg);
    assign last_cnt     = (cnt_reg == f_q_reg - CNT_W'(1));
    assign freq_clamped = (i_freq < CNT_W'(2)) ? CNT_W'(2) : i_freq;
    assign adc_ext      = {{(ACC_W-DATA_W){i_adc[DATA_W-1]}}, i_adc};

    // The final NEG sample is folded in here because its accumulator update never lands.
    assign pos_32 = {{(32-ACC_W){acc_pos_reg[ACC_W-1]}}, acc_pos_reg};
    assign neg_32 = {{(32-ACC_W){acc_neg_reg[ACC_W-1]}}, acc_neg_reg}
                  + (sample_en ? {{(32-DATA_W){i_adc[DATA_W-1]}}, i_adc} : 32'sd0);

`ifdef MYDEMOD_POL_SEL_EN
    assign err_next = pol_q_reg ? (neg_32 - pos_32) : (pos_32 - neg_32);
`else
    assign err_next = pos_32 - neg_32;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            f_q_reg     <= CNT_W'(2);
            ig_q_reg    <= '0;
            acc_pos_reg <= '0;
            acc_neg_reg <= '0;
            o_mod       <= 1'b0;
            o_err       <= '0;
            o_step_trig <= 1'b0;
`ifdef MYDEMOD_POL_SEL_EN
            pol_q_reg   <= 1'b0;
`endif
        end else begin
            o_step_trig <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_en) begin
                        state_reg   <= POS;
                        o_mod       <= 1'b1;
                        cnt_reg     <= '0;
                        acc_pos_reg <= '0;
                        acc_neg_reg <= '0;
                        f_q_reg     <= freq_clamped;
                        ig_q_reg    <= i_ignor;
`ifdef MYDEMOD_POL_SEL_EN
                        pol_q_reg   <= i_pol;
`endif
                    end
                end
                POS: begin
                    if (!i_en) begin
                        state_reg   <= IDLE;
                        o_mod       <= 1'b0;
                        cnt_reg     <= '0;
                        acc_pos_reg <= '0;
                        acc_neg_reg <= '0;
                    end else begin
                        if (sample_en) begin
                            acc_pos_reg <= acc_pos_reg + adc_ext;
                        end
                        if (last_cnt) begin
                            state_reg <= NEG;
                            o_mod     <= 1'b0;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                NEG: begin
                    if (!i_en) begin
                        state_reg   <= IDLE;
                        o_mod       <= 1'b0;
                        cnt_reg     <= '0;
                        acc_pos_reg <= '0;
                        acc_neg_reg <= '0;
                    end else if (last_cnt) begin
                        state_reg   <= POS;
                        o_mod       <= 1'b1;
                        cnt_reg     <= '0;
                        acc_pos_reg <= '0;
                        acc_neg_reg <= '0;
                        f_q_reg     <= freq_clamped;
                        ig_q_reg    <= i_ignor;
`ifdef MYDEMOD_POL_SEL_EN
                        pol_q_reg   <= i_pol;
`endif
                        o_err       <= err_next;
                        o_step_trig <= 1'b1;
                    end else begin
                        if (sample_en) begin
                            acc_neg_reg <= acc_neg_reg + adc_ext;
                        end
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    o_mod     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_sq_demod_gate.sv
// Directed bench for my_sq_demod_gate: period timing, ignore window, clamp, abort, config latching,
// async reset, and a full-scale no-wrap case on a narrow-counter instance.
module tb_my_sq_demod_gate;

    logic               clk;
    logic               n_rst;
    logic               i_en;
    logic [15:0]        i_freq;
    logic [15:0]        i_ignor;
    logic signed [13:0] i_adc;
    logic               i_pol;
    logic               o_mod;
    logic signed [31:0] o_err;
    logic               o_step_trig;

    logic               en2;
    logic [7:0]         freq2;
    logic [7:0]         ignor2;
    logic signed [13:0] adc2;
    logic               mod2;
    logic signed [31:0] err2;
    logic               trig2;

    int n_total = 0;
    int n_pass  = 0;

    // Stimulus levels follow the modulation phase: +100 while POS, -50 while NEG.
    assign i_adc = o_mod ? 14'sd100 : -14'sd50;
    assign adc2  = mod2 ? 14'sd8191 : -14'sd8192;

    my_sq_demod_gate #(.DATA_W(14), .CNT_W(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_en        (i_en),
        .i_freq      (i_freq),
        .i_ignor     (i_ignor),
        .i_adc       (i_adc),
`ifdef MYDEMOD_POL_SEL_EN
        .i_pol       (i_pol),
`endif
        .o_mod       (o_mod),
        .o_err       (o_err),
        .o_step_trig (o_step_trig)
    );

    my_sq_demod_gate #(.DATA_W(14), .CNT_W(8)) dut_fs (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_en        (en2),
        .i_freq      (freq2),
        .i_ignor     (ignor2),
        .i_adc       (adc2),
`ifdef MYDEMOD_POL_SEL_EN
        .i_pol       (1'b0),
`endif
        .o_mod       (mod2),
        .o_err       (err2),
        .o_step_trig (trig2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0d exp %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts edges until the strobe is seen; a timeout shows up as a wrong count.
    task automatic wait_strobe(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_step_trig && n < 1000);
        check(tag, n, exp_cycles);
    endtask

    task automatic run_count(input int cycles, output int strobes);
        strobes = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (o_step_trig) strobes++;
        end
    endtask

    task automatic start(input int f, input int ig);
        i_en = 1'b0;
        tick();
        tick();
        i_freq  = 16'(f);
        i_ignor = 16'(ig);
        i_en    = 1'b1;
        tick();
        check("start_mod", o_mod, 1);
    endtask

    initial begin
        int strobes;
        int mods;
        int n;

        n_rst = 1'b0; i_en = 1'b0; i_freq = 16'd10; i_ignor = 16'd2; i_pol = 1'b0;
        en2 = 1'b0; freq2 = 8'd255; ignor2 = 8'd0;
        repeat (3) tick();
        check("rst_mod", o_mod, 0);
        check("rst_err", o_err, 0);
        check("rst_trig", o_step_trig, 0);
        n_rst = 1'b1;

        strobes = 0; mods = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (o_step_trig) strobes++;
            if (o_mod) mods++;
        end
        check("idle_strobes", strobes, 0);
        check("idle_mod", mods, 0);
        check("idle_err", o_err, 0);

        // basic: 8 samples per half after skipping 2
        start(10, 2);
        wait_strobe("basic_first", 20);
        check("basic_err", o_err, 1200);
        tick();
        check("basic_pulse", o_step_trig, 0);
        wait_strobe("basic_second", 19);
        check("basic_err2", o_err, 1200);

        start(10, 12);
        wait_strobe("skip_period", 20);
        check("skip_err", o_err, 0);

        start(10, 9);
        wait_strobe("ig_edge_per", 20);
        check("ig_edge_err", o_err, 150);

        start(1, 0);
        wait_strobe("clamp_first", 4);
        check("clamp_err", o_err, 300);
        wait_strobe("clamp_second", 4);

        // abort during NEG cnt=5, re-enable three clocks later
        start(10, 2);
        run_count(15, strobes);
        i_en = 1'b0;
        run_count(3, n);
        check("abort_strobes", strobes + n, 0);
        check("abort_mod", o_mod, 0);
        check("abort_err_hold", o_err, 300);
        i_en = 1'b1;
        tick();
        wait_strobe("abort_reentry", 20);
        check("abort_err", o_err, 1200);
        repeat (19) tick();
        i_en = 1'b0;
        tick();
        check("lastneg_trig", o_step_trig, 0);
        check("lastneg_mod", o_mod, 0);

        // mid-period config change only applies at the boundary
        start(10, 2);
        repeat (3) tick();
        i_freq = 16'd6;
        wait_strobe("cfg_cur_period", 17);
        check("cfg_cur_err", o_err, 1200);
        wait_strobe("cfg_new_period", 12);
        check("cfg_new_err", o_err, 600);

`ifdef MYDEMOD_POL_SEL_EN
        i_pol = 1'b1;
        start(10, 2);
        wait_strobe("pol_period", 20);
        check("pol_err", o_err, -1200);
        i_pol = 1'b0;
`endif

        // async reset mid-period clears outputs without a clock edge
        start(10, 2);
        repeat (5) tick();
        n_rst = 1'b0;
        #1;
        check("arst_mod", o_mod, 0);
        check("arst_err", o_err, 0);
        check("arst_trig", o_step_trig, 0);
        i_en = 1'b0;
        tick();
        n_rst = 1'b1;
        run_count(25, strobes);
        check("arst_after", strobes, 0);

        // full scale on the 8-bit counter instance: accumulators sit at their widest
        en2 = 1'b1;
        tick();
        check("fs_mod", mod2, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!trig2 && n < 2000);
        check("fs_period", n, 510);
        check("fs_err", err2, 4177665);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
